// File: rtl/mshr_sched_pkg.sv
// mshr_sched_pkg
// Shared types and constants for the L2 MSHR miss scheduler: the issue and
// fill FSM state encodings and the width of the optional statistics counters.
package mshr_sched_pkg;

  localparam int CNT_W = 16;

  typedef enum logic {
    ISS_IDLE,
    ISS_WAIT
  } iss_state_t;

  typedef enum logic [1:0] {
    F_IDLE,
    F_GET,
    F_RET
  } fill_state_t;

endpackage

// File: rtl/mshr_miss_scheduler_rr_arbiter.sv
// rr_arbiter
// Combinational round-robin picker. The search starts at ptr and wraps, so
// the first requester at or after ptr wins.
// Ports:
//   req   - request vector, one bit per requester
//   ptr   - requester index with highest priority this cycle
//   grant - one-hot winner (all zero when no request)
//   idx   - encoded winner (zero when no request)
// N must be a power of two: the wrap is done by W-bit overflow of ptr+i.
module rr_arbiter #(
  parameter int N = 4,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] grant,
  output logic [W-1:0] idx
);

  logic [W-1:0] cand;

  // Walk from lowest to highest priority so the last hit (closest to ptr) sticks.
  always_comb begin
    grant = '0;
    idx   = '0;
    cand  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      cand = ptr + W'(i);
      if (req[cand]) begin
        grant       = '0;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/mshr_miss_scheduler.sv
// mshr_miss_scheduler
// Sequences the L2 MSHR: round-robin admission of per-CPU misses into the
// MSHR add port, issue of pending entries to memory (one outstanding request),
// and retirement of memory fills (get, then del plus a fill to the CPU).
// Ports:
//   clk, reset (synchronous, active-low), enable (low freezes all state)
//   req_*        per-CPU miss requests, packed with CPU i at slice i
//   mshr_add_*   / mshr_comp_*   arbitration winner towards the MSHR
//   mshr_rn_*    head of the MSHR issue list, mshr_read_next pops it
//   mem_req_*    / mem_resp_*    memory request/response channel
//   mshr_get_* / mshr_del_*      MSHR lookup and retirement on fill
//   fill_*       one-cycle fill return to the requesting CPU
//   stale_resp   response tag not valid in the MSHR
//   stat_*       statistics, built only when MSHR_SCHED_STATS_EN is defined
module mshr_miss_scheduler
  import mshr_sched_pkg::*;
#(
  parameter int addr_bits     = 20,
  parameter int data_bits     = 90,
  parameter int mshr_tag_bits = 3,
  parameter int cpu_id_bits   = 2,
  parameter int ASSOC_BITS    = 2,
  localparam int NCPU = 2 ** cpu_id_bits
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [NCPU-1:0]            req_valid,
  input  logic [NCPU*addr_bits-1:0]  req_addr,
  input  logic [NCPU*data_bits-1:0]  req_data,
  input  logic [NCPU-1:0]            req_rw,
  input  logic [NCPU-1:0]            req_dirty,
  input  logic [NCPU*ASSOC_BITS-1:0] req_victim,
  output logic [NCPU-1:0]            req_ready,
  output logic                       mshr_add,
  output logic [addr_bits-1:0]       mshr_add_addr,
  output logic [data_bits-1:0]       mshr_add_data,
  output logic                       mshr_add_rw,
  output logic                       mshr_add_dirty,
  output logic [cpu_id_bits-1:0]     mshr_add_cpu_id,
  output logic [ASSOC_BITS-1:0]      mshr_add_victim,
  output logic [addr_bits-1:0]       mshr_comp_addr,
  output logic [ASSOC_BITS-1:0]      mshr_comp_victim,
  input  logic                       mshr_comp_true,
  input  logic                       mshr_full,
  input  logic                       mshr_empty,
  output logic                       mshr_read_next,
  input  logic                       mshr_rn_valid,
  input  logic [addr_bits-1:0]       mshr_rn_addr,
  input  logic [data_bits-1:0]       mshr_rn_data,
  input  logic                       mshr_rn_rw,
  input  logic [mshr_tag_bits-1:0]   mshr_rn_mshr_id,
  output logic                       mem_req_valid,
  input  logic                       mem_req_ready,
  output logic [addr_bits-1:0]       mem_req_addr,
  output logic [data_bits-1:0]       mem_req_data,
  output logic                       mem_req_rw,
  output logic [mshr_tag_bits-1:0]   mem_req_tag,
  input  logic                       mem_resp_valid,
  output logic                       mem_resp_ready,
  input  logic [mshr_tag_bits-1:0]   mem_resp_tag,
  input  logic [data_bits-1:0]       mem_resp_data,
  output logic                       mshr_get,
  output logic [mshr_tag_bits-1:0]   mshr_get_tag,
  input  logic                       mshr_get_valid,
  input  logic [addr_bits-1:0]       mshr_get_addr,
  input  logic [cpu_id_bits-1:0]     mshr_get_cpu_id,
  input  logic [ASSOC_BITS-1:0]      mshr_get_victim,
  output logic                       mshr_del,
  output logic [mshr_tag_bits-1:0]   mshr_del_tag,
  output logic                       fill_valid,
  output logic [cpu_id_bits-1:0]     fill_cpu_id,
  output logic [addr_bits-1:0]       fill_addr,
  output logic [data_bits-1:0]       fill_data,
  output logic [ASSOC_BITS-1:0]      fill_victim,
  output logic                       stale_resp,
  output logic [CNT_W-1:0]           stat_conflicts,
  output logic [CNT_W-1:0]           stat_issued,
  output logic [CNT_W-1:0]           stat_fills
);

  // Strobes are qualified by reset too, so every output is quiet while reset is held.
  logic run;
  assign run = reset & enable;

  // ---------------- add path: arbitration, zero latency ----------------
  logic [cpu_id_bits-1:0] rr_ptr;
  logic [cpu_id_bits-1:0] win_idx;
  logic [NCPU-1:0]        win_onehot;
  logic                   any_req;
  logic                   add_ok;

  rr_arbiter #(.N(NCPU)) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (win_onehot),
    .idx   (win_idx)
  );

  assign any_req   = |req_valid;
  assign add_ok    = run & any_req & ~mshr_full & ~mshr_comp_true;
  assign req_ready = add_ok ? win_onehot : '0;
  assign mshr_add  = add_ok;

  // Winner fields are presented whenever someone requests, so the MSHR can
  // run its address compare before the grant is decided.
  always_comb begin
    mshr_add_addr   = '0;
    mshr_add_data   = '0;
    mshr_add_rw     = 1'b0;
    mshr_add_dirty  = 1'b0;
    mshr_add_cpu_id = '0;
    mshr_add_victim = '0;
    if (reset && any_req) begin
      mshr_add_addr   = req_addr[int'(win_idx)*addr_bits +: addr_bits];
      mshr_add_data   = req_data[int'(win_idx)*data_bits +: data_bits];
      mshr_add_rw     = req_rw[win_idx];
      mshr_add_dirty  = req_dirty[win_idx];
      mshr_add_cpu_id = win_idx;
      mshr_add_victim = req_victim[int'(win_idx)*ASSOC_BITS +: ASSOC_BITS];
    end
  end

  assign mshr_comp_addr   = mshr_add_addr;
  assign mshr_comp_victim = mshr_add_victim;

  always_ff @(posedge clk) begin
    if (!reset)      rr_ptr <= '0;
    else if (add_ok) rr_ptr <= win_idx + cpu_id_bits'(1);
  end

  // ---------------- issue FSM: one outstanding memory request ----------------
  iss_state_t iss_state;

  assign mshr_read_next = run & (iss_state == ISS_IDLE) & ~mshr_empty & mshr_rn_valid;
  assign mem_req_valid  = run & (iss_state == ISS_WAIT);

  always_ff @(posedge clk) begin
    if (!reset) begin
      iss_state    <= ISS_IDLE;
      mem_req_addr <= '0;
      mem_req_data <= '0;
      mem_req_rw   <= 1'b0;
      mem_req_tag  <= '0;
    end else if (enable) begin
      case (iss_state)
        ISS_IDLE: if (mshr_read_next) begin
          mem_req_addr <= mshr_rn_addr;
          mem_req_data <= mshr_rn_data;
          mem_req_rw   <= mshr_rn_rw;
          mem_req_tag  <= mshr_rn_mshr_id;
          iss_state    <= ISS_WAIT;
        end
        ISS_WAIT: if (mem_req_ready) iss_state <= ISS_IDLE;
      endcase
    end
  end

  // ---------------- fill FSM: accept, look up, retire ----------------
  fill_state_t             f_state;
  logic [mshr_tag_bits-1:0] resp_tag_q;

  assign mem_resp_ready = run & (f_state == F_IDLE);
  assign mshr_get       = run & (f_state == F_GET);
  assign stale_resp     = mshr_get & ~mshr_get_valid;
  assign mshr_del       = run & (f_state == F_RET);
  assign fill_valid     = mshr_del;
  assign mshr_get_tag   = resp_tag_q;
  assign mshr_del_tag   = resp_tag_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      f_state     <= F_IDLE;
      resp_tag_q  <= '0;
      fill_data   <= '0;
      fill_cpu_id <= '0;
      fill_addr   <= '0;
      fill_victim <= '0;
    end else if (enable) begin
      case (f_state)
        F_IDLE: if (mem_resp_valid) begin
          resp_tag_q <= mem_resp_tag;
          fill_data  <= mem_resp_data;
          f_state    <= F_GET;
        end
        F_GET: begin
          // A tag the MSHR no longer holds is dropped without a fill.
          if (mshr_get_valid) begin
            fill_cpu_id <= mshr_get_cpu_id;
            fill_addr   <= mshr_get_addr;
            fill_victim <= mshr_get_victim;
            f_state     <= F_RET;
          end else begin
            f_state <= F_IDLE;
          end
        end
        F_RET:   f_state <= F_IDLE;
        default: f_state <= F_IDLE;
      endcase
    end
  end

  // ---------------- optional statistics ----------------
`ifdef MSHR_SCHED_STATS_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) begin
      stat_conflicts <= '0;
      stat_issued    <= '0;
      stat_fills     <= '0;
    end else if (enable) begin
      if (any_req && mshr_comp_true) stat_conflicts <= sat_inc(stat_conflicts);
      if (mshr_read_next)            stat_issued    <= sat_inc(stat_issued);
      if (fill_valid)                stat_fills     <= sat_inc(stat_fills);
    end
  end
`else
  assign stat_conflicts = '0;
  assign stat_issued    = '0;
  assign stat_fills     = '0;
`endif

endmodule

// File: tb/tb_mshr_miss_scheduler.sv
module tb_mshr_miss_scheduler;

  localparam int AB = 20;
  localparam int DB = 90;
  localparam int TB = 3;
  localparam int CB = 2;
  localparam int VB = 2;
  localparam int N  = 4;
`ifdef MSHR_SCHED_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  logic clk = 1'b0;
  logic reset, enable;
  logic [N-1:0] req_valid, req_rw, req_dirty, req_ready;
  logic [N*AB-1:0] req_addr;
  logic [N*DB-1:0] req_data;
  logic [N*VB-1:0] req_victim;
  logic mshr_add, mshr_add_rw, mshr_add_dirty;
  logic [AB-1:0] mshr_add_addr, mshr_comp_addr;
  logic [DB-1:0] mshr_add_data;
  logic [CB-1:0] mshr_add_cpu_id;
  logic [VB-1:0] mshr_add_victim, mshr_comp_victim;
  logic mshr_comp_true, mshr_full, mshr_empty, mshr_read_next;
  logic mshr_rn_valid, mshr_rn_rw;
  logic [AB-1:0] mshr_rn_addr;
  logic [DB-1:0] mshr_rn_data;
  logic [TB-1:0] mshr_rn_mshr_id;
  logic mem_req_valid, mem_req_ready, mem_req_rw;
  logic [AB-1:0] mem_req_addr;
  logic [DB-1:0] mem_req_data;
  logic [TB-1:0] mem_req_tag;
  logic mem_resp_valid, mem_resp_ready;
  logic [TB-1:0] mem_resp_tag;
  logic [DB-1:0] mem_resp_data;
  logic mshr_get, mshr_get_valid, mshr_del;
  logic [TB-1:0] mshr_get_tag, mshr_del_tag;
  logic [AB-1:0] mshr_get_addr, fill_addr;
  logic [CB-1:0] mshr_get_cpu_id, fill_cpu_id;
  logic [VB-1:0] mshr_get_victim, fill_victim;
  logic fill_valid, stale_resp;
  logic [DB-1:0] fill_data;
  logic [15:0] stat_conflicts, stat_issued, stat_fills;

  mshr_miss_scheduler dut (
    .clk(clk), .reset(reset), .enable(enable),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_rw(req_rw), .req_dirty(req_dirty), .req_victim(req_victim),
    .req_ready(req_ready), .mshr_add(mshr_add),
    .mshr_add_addr(mshr_add_addr), .mshr_add_data(mshr_add_data),
    .mshr_add_rw(mshr_add_rw), .mshr_add_dirty(mshr_add_dirty),
    .mshr_add_cpu_id(mshr_add_cpu_id), .mshr_add_victim(mshr_add_victim),
    .mshr_comp_addr(mshr_comp_addr), .mshr_comp_victim(mshr_comp_victim),
    .mshr_comp_true(mshr_comp_true), .mshr_full(mshr_full), .mshr_empty(mshr_empty),
    .mshr_read_next(mshr_read_next), .mshr_rn_valid(mshr_rn_valid),
    .mshr_rn_addr(mshr_rn_addr), .mshr_rn_data(mshr_rn_data),
    .mshr_rn_rw(mshr_rn_rw), .mshr_rn_mshr_id(mshr_rn_mshr_id),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
    .mem_req_rw(mem_req_rw), .mem_req_tag(mem_req_tag),
    .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready),
    .mem_resp_tag(mem_resp_tag), .mem_resp_data(mem_resp_data),
    .mshr_get(mshr_get), .mshr_get_tag(mshr_get_tag),
    .mshr_get_valid(mshr_get_valid), .mshr_get_addr(mshr_get_addr),
    .mshr_get_cpu_id(mshr_get_cpu_id), .mshr_get_victim(mshr_get_victim),
    .mshr_del(mshr_del), .mshr_del_tag(mshr_del_tag),
    .fill_valid(fill_valid), .fill_cpu_id(fill_cpu_id), .fill_addr(fill_addr),
    .fill_data(fill_data), .fill_victim(fill_victim), .stale_resp(stale_resp),
    .stat_conflicts(stat_conflicts), .stat_issued(stat_issued), .stat_fills(stat_fills)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change just after the active edge; outputs are checked on the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0; enable = 1'b1;
    req_valid = '0; req_addr = '0; req_data = '0; req_rw = '0; req_dirty = '0; req_victim = '0;
    mshr_comp_true = 1'b0; mshr_full = 1'b0; mshr_empty = 1'b1;
    mshr_rn_valid = 1'b0; mshr_rn_addr = '0; mshr_rn_data = '0; mshr_rn_rw = 1'b0; mshr_rn_mshr_id = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_tag = '0; mem_resp_data = '0;
    mshr_get_valid = 1'b0; mshr_get_addr = '0; mshr_get_cpu_id = '0; mshr_get_victim = '0;

    // Reset held with a request present: nothing may be granted.
    next_cycle();
    req_valid = 4'b0001;
    settle();
    chk("rst_req_ready", req_ready, 0);
    chk("rst_mshr_add", mshr_add, 0);
    chk("rst_add_addr", mshr_add_addr, 0);
    chk("rst_resp_ready", mem_resp_ready, 0);
    chk("rst_mem_req_valid", mem_req_valid, 0);
    chk("rst_stat_conflicts", stat_conflicts, 0);

    // CPU0 and CPU2 request: CPU0 first, then CPU2, then wrap to CPU0.
    next_cycle();
    reset = 1'b1;
    req_valid = 4'b0101;
    req_addr[0*AB +: AB] = 20'h11111;
    req_addr[2*AB +: AB] = 20'h22222;
    req_data[2*DB +: DB] = 90'h2_0000_0000_0000_00C0_FFEE;
    req_rw[2] = 1'b1; req_dirty[2] = 1'b1; req_victim[2*VB +: VB] = 2'd3;
    settle();
    chk("arb0_ready", req_ready, 4'b0001);
    chk("arb0_add", mshr_add, 1);
    chk("arb0_addr", mshr_add_addr, 20'h11111);
    chk("arb0_cpu", mshr_add_cpu_id, 0);
    chk("idle_resp_ready", mem_resp_ready, 1);
    chk("idle_read_next", mshr_read_next, 0);

    next_cycle();
    settle();
    chk("arb1_ready", req_ready, 4'b0100);
    chk("arb1_cpu", mshr_add_cpu_id, 2);
    chk("arb1_comp_addr", mshr_comp_addr, 20'h22222);
    chk("arb1_data", mshr_add_data, 90'h2_0000_0000_0000_00C0_FFEE);
    chk("arb1_rw", mshr_add_rw, 1);
    chk("arb1_dirty", mshr_add_dirty, 1);
    chk("arb1_victim", mshr_comp_victim, 3);

    next_cycle();
    settle();
    chk("arb2_wrap_ready", req_ready, 4'b0001);

    // Full then conflict: no grant, pointer (now 1) must hold.
    next_cycle();
    req_valid = 4'b0010;
    req_addr[1*AB +: AB] = 20'h00A40;
    mshr_full = 1'b1;
    settle();
    chk("full_ready", req_ready, 0);
    chk("full_add", mshr_add, 0);

    next_cycle();
    mshr_full = 1'b0;
    mshr_comp_true = 1'b1;
    settle();
    chk("conf_ready", req_ready, 0);
    chk("conf_add", mshr_add, 0);
    chk("conf_comp_addr", mshr_comp_addr, 20'h00A40);

    next_cycle();
    settle();
    chk("conf_stat1", stat_conflicts, STATS ? 1 : 0);

    next_cycle();
    mshr_comp_true = 1'b0;
    req_valid = 4'b0110;
    settle();
    chk("conf_stat2", stat_conflicts, STATS ? 2 : 0);
    chk("ptr_held_ready", req_ready, 4'b0010);
    chk("ptr_held_cpu", mshr_add_cpu_id, 1);

    next_cycle();
    settle();
    chk("after_held_ready", req_ready, 4'b0100);

    // Disabled: no strobes.
    next_cycle();
    enable = 1'b0;
    req_valid = 4'b0001;
    settle();
    chk("dis_ready", req_ready, 0);
    chk("dis_add", mshr_add, 0);
    chk("dis_resp_ready", mem_resp_ready, 0);

    // Issue with mem_req_ready low for 3 cycles.
    next_cycle();
    enable = 1'b1;
    req_valid = '0;
    mshr_empty = 1'b0; mshr_rn_valid = 1'b1; mshr_rn_mshr_id = 3'd5;
    mshr_rn_addr = 20'h0ABCD; mshr_rn_rw = 1'b1; mshr_rn_data = 90'h3_1234;
    settle();
    chk("iss_read_next", mshr_read_next, 1);
    chk("iss_valid_early", mem_req_valid, 0);

    for (int k = 0; k < 3; k++) begin
      next_cycle();
      settle();
      chk("iss_wait_rn", mshr_read_next, 0);
      chk("iss_wait_valid", mem_req_valid, 1);
      chk("iss_wait_tag", mem_req_tag, 5);
    end
    chk("iss_addr", mem_req_addr, 20'h0ABCD);
    chk("iss_rw", mem_req_rw, 1);
    chk("iss_data", mem_req_data, 90'h3_1234);

    next_cycle();
    mem_req_ready = 1'b1;
    settle();
    chk("iss_hs_valid", mem_req_valid, 1);
    chk("iss_hs_tag", mem_req_tag, 5);

    next_cycle();
    mem_req_ready = 1'b0;
    mshr_rn_mshr_id = 3'd2;
    settle();
    chk("iss2_read_next", mshr_read_next, 1);
    chk("iss2_valid_low", mem_req_valid, 0);

    next_cycle();
    mshr_empty = 1'b1; mshr_rn_valid = 1'b0;
    settle();
    chk("iss2_valid", mem_req_valid, 1);
    chk("iss2_tag", mem_req_tag, 2);

    // Fill with a valid MSHR entry.
    next_cycle();
    mem_resp_valid = 1'b1; mem_resp_tag = 3'd3; mem_resp_data = 90'h2A5;
    settle();
    chk("fill_accept_ready", mem_resp_ready, 1);
    chk("fill_accept_get", mshr_get, 0);

    next_cycle();
    mem_resp_valid = 1'b0;
    mshr_get_valid = 1'b1; mshr_get_cpu_id = 2'd2; mshr_get_addr = 20'h0BEEF; mshr_get_victim = 2'd1;
    settle();
    chk("fill_get", mshr_get, 1);
    chk("fill_get_tag", mshr_get_tag, 3);
    chk("fill_get_ready", mem_resp_ready, 0);
    chk("fill_get_fv", fill_valid, 0);
    chk("fill_get_stale", stale_resp, 0);

    next_cycle();
    mshr_get_valid = 1'b0;
    settle();
    chk("fill_valid", fill_valid, 1);
    chk("fill_del", mshr_del, 1);
    chk("fill_del_tag", mshr_del_tag, 3);
    chk("fill_cpu", fill_cpu_id, 2);
    chk("fill_addr", fill_addr, 20'h0BEEF);
    chk("fill_victim", fill_victim, 1);
    chk("fill_data", fill_data, 90'h2A5);
    chk("fill_ret_ready", mem_resp_ready, 0);

    next_cycle();
    settle();
    chk("fill_done_fv", fill_valid, 0);
    chk("fill_done_del", mshr_del, 0);
    chk("fill_done_ready", mem_resp_ready, 1);

    // Stale response.
    next_cycle();
    mem_resp_valid = 1'b1; mem_resp_tag = 3'd6;
    settle();
    chk("stale_accept", mem_resp_ready, 1);

    next_cycle();
    mem_resp_valid = 1'b0;
    settle();
    chk("stale_get", mshr_get, 1);
    chk("stale_get_tag", mshr_get_tag, 6);
    chk("stale_pulse", stale_resp, 1);

    next_cycle();
    settle();
    chk("stale_off", stale_resp, 0);
    chk("stale_no_fill", fill_valid, 0);
    chk("stale_no_del", mshr_del, 0);
    chk("stale_ready", mem_resp_ready, 1);
    chk("stat_issued", stat_issued, STATS ? 2 : 0);
    chk("stat_fills", stat_fills, STATS ? 1 : 0);

    // Reset while the fill FSM is in F_GET and the issue FSM in ISS_WAIT.
    next_cycle();
    mem_resp_valid = 1'b1; mem_resp_tag = 3'd4;
    settle();

    next_cycle();
    mem_resp_valid = 1'b0;
    mshr_get_valid = 1'b1;
    settle();
    chk("pre_rst_get", mshr_get, 1);
    chk("pre_rst_mem_valid", mem_req_valid, 1);
    reset = 1'b0;

    next_cycle();
    settle();
    chk("mid_rst_mem_valid", mem_req_valid, 0);
    chk("mid_rst_get", mshr_get, 0);
    chk("mid_rst_fill", fill_valid, 0);
    chk("mid_rst_del", mshr_del, 0);
    chk("mid_rst_tag", mem_req_tag, 0);
    chk("mid_rst_get_tag", mshr_get_tag, 0);
    chk("mid_rst_stat_issued", stat_issued, 0);

    next_cycle();
    reset = 1'b1;
    mshr_get_valid = 1'b0;
    settle();
    chk("post_rst_resp_ready", mem_resp_ready, 1);
    chk("post_rst_mem_valid", mem_req_valid, 0);
    chk("post_rst_get", mshr_get, 0);
    chk("post_rst_fill", fill_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
